// File: rtl/fir_data_buf.sv
// Circular-buffer controller for the FIR data RAM: writes each accepted sample at a
// wrapping pointer, then replays the last TAPS samples newest-first to the MAC stage.
module fir_data_buf #(
  parameter int TAPS = 11,
  parameter int AW   = 7,
  parameter int TW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic [3:0]    ram_we,
  output logic          ram_en,
  output logic [31:0]   ram_di,
  output logic [AW-1:0] ram_a,
  input  logic [31:0]   ram_do,
  output logic          m_valid,
  output logic [31:0]   m_data,
  output logic [TW-1:0] m_tap,
  output logic          m_first,
  output logic          m_last
);

  typedef enum logic [1:0] {INIT, IDLE, READ, DRAIN} state_t;

  localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
  localparam logic [TW:0]   TAPS_W   = (TW+1)'(TAPS);

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;     // zeroing index i in INIT, tap index k in READ
  logic [TW-1:0] wptr, wptr_nxt;
  logic [TW:0]   rd_addr;
  logic          rd_issue, out_ld;

  // (wptr - k) mod TAPS without a divider; one extra bit covers wptr + TAPS
  always_comb begin
    if (wptr >= cnt) rd_addr = {1'b0, wptr} - {1'b0, cnt};
    else             rd_addr = {1'b0, wptr} + TAPS_W - {1'b0, cnt};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wptr_nxt  = wptr;
    s_ready   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_a     = '0;
    ram_di    = '0;
    rd_issue  = 1'b0;
    case (state)
      INIT: begin
        ram_en = 1'b1;
        ram_we = 4'hF;
        ram_a  = AW'(cnt);
        if (cnt == TAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          wptr_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ram_en    = 1'b1;
          ram_we    = 4'hF;
          ram_a     = AW'(wptr);
          ram_di    = s_data;
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      READ: begin
        ram_en   = 1'b1;
        ram_a    = AW'(rd_addr);
        rd_issue = 1'b1;
        if (cnt == TAP_LAST) state_nxt = DRAIN;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      DRAIN: begin
        wptr_nxt  = (wptr == TAP_LAST) ? '0 : wptr + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
    if (RST || flush) begin
      state_nxt = INIT;
      cnt_nxt   = '0;
      wptr_nxt  = '0;
    end
  end

  // a read cut short by flush must not surface on the output
  assign out_ld = rd_issue && !flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= INIT;
      cnt     <= '0;
      wptr    <= '0;
      m_valid <= 1'b0;
      m_tap   <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wptr    <= wptr_nxt;
      m_valid <= out_ld;
      m_tap   <= out_ld ? cnt : '0;
      m_first <= out_ld && (cnt == '0);
      m_last  <= out_ld && (cnt == TAP_LAST);
    end
  end

  // RAM read data is already the registered stage; gate it so idle beats read as zero
  assign m_data = m_valid ? ram_do : 32'h0;

endmodule

// File: tb/tb_fir_data_buf.sv
// Directed bench for fir_data_buf: TAPS=11 instance plus a TAPS=1 instance, each
// with a byte-write single-port RAM model.
module tb_fir_data_buf;
  localparam int TAPS = 11;
  localparam int AW   = 7;
  localparam int TW   = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, flush, s_valid, s_ready;
  logic [31:0]   s_data, ram_di, ram_do, m_data;
  logic [3:0]    ram_we;
  logic          ram_en, m_valid, m_first, m_last;
  logic [AW-1:0] ram_a;
  logic [TW-1:0] m_tap;

  logic          flush1, s_valid1, s_ready1, ram_en1, m_valid1, m_first1, m_last1;
  logic [31:0]   s_data1, ram_di1, ram_do1, m_data1;
  logic [3:0]    ram_we1;
  logic [AW-1:0] ram_a1;
  logic [0:0]    m_tap1;

  fir_data_buf #(.TAPS(TAPS), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .ram_we(ram_we), .ram_en(ram_en), .ram_di(ram_di), .ram_a(ram_a),
    .ram_do(ram_do), .m_valid(m_valid), .m_data(m_data), .m_tap(m_tap),
    .m_first(m_first), .m_last(m_last));

  fir_data_buf #(.TAPS(1), .AW(AW)) dut1 (
    .CLK(CLK), .RST(RST), .flush(flush1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .ram_we(ram_we1), .ram_en(ram_en1), .ram_di(ram_di1), .ram_a(ram_a1),
    .ram_do(ram_do1), .m_valid(m_valid1), .m_data(m_data1), .m_tap(m_tap1),
    .m_first(m_first1), .m_last(m_last1));

  // RAM models: 1-cycle read latency, output 0 when not enabled or writing
  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] mem1 [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem0[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= (ram_we == 4'h0) ? mem0[ram_a] : 32'h0;
    end else ram_do <= 32'h0;
    if (ram_en1) begin
      for (int b = 0; b < 4; b++) if (ram_we1[b]) mem1[ram_a1][8*b +: 8] <= ram_di1[8*b +: 8];
      ram_do1 <= (ram_we1 == 4'h0) ? mem1[ram_a1] : 32'h0;
    end else ram_do1 <= 32'h0;
  end

  int cyc_cnt = 0;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  int            n_chk = 0;
  int            n_err = 0;
  logic [31:0]   ref_mem [0:TAPS-1];
  int            ref_wptr;
  int            acc_cyc;
  logic [AW-1:0] obs_a [0:TAPS-1];
  logic [31:0]   obs_d [0:TAPS-1];

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic ref_clear();
    for (int j = 0; j < TAPS; j++) ref_mem[j] = 32'h0;
    ref_wptr = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 32'h0;
    flush1 = 1'b0; s_valid1 = 1'b0; s_data1 = 32'h0;
    step(); step(); #1;
    n_chk++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 32'h0 || m_tap !== 4'h0 ||
        m_first !== 1'b0 || m_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b rdy=%b d=%h tap=%0d f=%b l=%b, want all 0",
               m_valid, s_ready, m_data, m_tap, m_first, m_last);
    end
    RST = 1'b0;
    for (int c = 0; c < TAPS; c++) begin
      #1;
      n_chk++;
      if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_a !== AW'(c) || ram_di !== 32'h0 ||
          s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL init_zero[%0d]: got en=%b we=%h a=%0d di=%h rdy=%b, want 1 F %0d 0 0",
                 c, ram_en, ram_we, ram_a, ram_di, s_ready, c);
      end
      step();
    end
    #1;
    n_chk++;
    if (s_ready !== 1'b1 || ram_en !== 1'b0) begin
      n_err++;
      $display("FAIL init_done: got rdy=%b en=%b, want 1 0", s_ready, ram_en);
    end
    ref_clear();
  endtask

  // Sends one sample and checks the write, every read issue and every output beat.
  task automatic run_sample(input logic [31:0] v, input bit keep, input string tag);
    int w, k, j, ea;
    logic [31:0] ed;
    s_valid = 1'b1; s_data = v; #1;
    w = 0;
    while (s_ready !== 1'b1 && w < 40) begin step(); #1; w++; end
    n_chk++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept_timeout: got rdy=%b, want 1 within 40 cycles", tag, s_ready);
      s_valid = 1'b0;
      return;
    end
    n_chk++;
    if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_a !== AW'(ref_wptr) || ram_di !== v) begin
      n_err++;
      $display("FAIL %s write: got en=%b we=%h a=%0d di=%h, want 1 F %0d %h",
               tag, ram_en, ram_we, ram_a, ram_di, ref_wptr, v);
    end
    acc_cyc = cyc_cnt;
    ref_mem[ref_wptr] = v;
    step();
    if (keep) s_data = v + 32'd1; else s_valid = 1'b0;
    for (int c = 1; c <= TAPS + 1; c++) begin
      #1;
      n_chk++;
      if (s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy_ready c%0d: got %b want 0", tag, c, s_ready);
      end
      if (c <= TAPS) begin
        k = c - 1;
        ea = (ref_wptr - k + TAPS) % TAPS;
        obs_a[k] = ram_a;
        n_chk++;
        if (ram_en !== 1'b1 || ram_we !== 4'h0 || ram_a !== AW'(ea)) begin
          n_err++;
          $display("FAIL %s read k%0d: got en=%b we=%h a=%0d, want 1 0 %0d",
                   tag, k, ram_en, ram_we, ram_a, ea);
        end
      end else begin
        n_chk++;
        if (ram_en !== 1'b0) begin
          n_err++;
          $display("FAIL %s drain_en: got %b want 0", tag, ram_en);
        end
      end
      if (c == 1) begin
        n_chk++;
        if (m_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s early_valid: got %b want 0", tag, m_valid);
        end
      end else begin
        j = c - 2;
        ed = ref_mem[(ref_wptr - j + TAPS) % TAPS];
        obs_d[j] = m_data;
        n_chk++;
        if (m_valid !== 1'b1 || m_tap !== TW'(j) || m_data !== ed ||
            m_first !== (j == 0) || m_last !== (j == TAPS - 1)) begin
          n_err++;
          $display("FAIL %s beat%0d: got v=%b tap=%0d d=%h f=%b l=%b, want 1 %0d %h %b %b",
                   tag, j, m_valid, m_tap, m_data, m_first, m_last, j, ed, j == 0, j == TAPS - 1);
        end
      end
      step();
    end
    #1;
    n_chk++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready_return: got rdy=%b v=%b, want 1 0", tag, s_ready, m_valid);
    end
    ref_wptr = (ref_wptr + 1) % TAPS;
  endtask

  task automatic test_single();
    logic bad;
    run_sample(32'h5, 1'b0, "single");
    bad = (obs_d[0] !== 32'h5);
    for (int k = 1; k < TAPS; k++) if (obs_d[k] !== 32'h0) bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_err++;
      $display("FAIL single_seq: got first=%h last=%h, want 5 then zeros", obs_d[0], obs_d[TAPS-1]);
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    int exp_a13 [0:10] = '{1, 0, 10, 9, 8, 7, 6, 5, 4, 3, 2};
    test_reset();
    prev = 0;
    for (int s = 1; s <= 13; s++) begin
      run_sample(32'(s), 1'b1, "b2b");
      if (s > 1) begin
        n_chk++;
        if (acc_cyc - prev != TAPS + 2) begin
          n_err++;
          $display("FAIL b2b_period s%0d: got %0d cycles want %0d", s, acc_cyc - prev, TAPS + 2);
        end
      end
      prev = acc_cyc;
    end
    s_valid = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      n_chk++;
      if (obs_a[k] !== AW'(exp_a13[k]) || obs_d[k] !== 32'(13 - k)) begin
        n_err++;
        $display("FAIL wrap k%0d: got a=%0d d=%0d, want a=%0d d=%0d",
                 k, obs_a[k], obs_d[k], exp_a13[k], 13 - k);
      end
    end
  endtask

  task automatic test_flush();
    logic bad;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; #1;
    n_chk++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre_ready: got %b want 1", s_ready);
    end
    step(); s_valid = 1'b0;
    repeat (4) step();
    #1;
    n_chk++;
    if (ram_a !== AW'(9) || ram_en !== 1'b1) begin
      n_err++;
      $display("FAIL flush_k4_addr: got a=%0d en=%b want 9 1", ram_a, ram_en);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < TAPS; c++) begin
      #1;
      n_chk++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || ram_we !== 4'hF || ram_a !== AW'(c) ||
          ram_di !== 32'h0) begin
        n_err++;
        $display("FAIL flush_zero[%0d]: got v=%b rdy=%b we=%h a=%0d di=%h, want 0 0 F %0d 0",
                 c, m_valid, s_ready, ram_we, ram_a, ram_di, c);
      end
      step();
    end
    ref_clear();
    run_sample(32'h77, 1'b0, "postflush");
    bad = (obs_d[0] !== 32'h77);
    for (int k = 1; k < TAPS; k++) if (obs_d[k] !== 32'h0) bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_err++;
      $display("FAIL postflush_seq: got first=%h k1=%h, want 77 then zeros", obs_d[0], obs_d[1]);
    end
  endtask

  task automatic test_taps1();
    logic [31:0] vals [0:2] = '{32'hA5A5_0001, 32'h0000_FFFF, 32'h8000_0000};
    RST = 1'b1; s_valid1 = 1'b0;
    step(); step(); #1;
    n_chk++;
    if (m_valid1 !== 1'b0 || s_ready1 !== 1'b0 || m_data1 !== 32'h0) begin
      n_err++;
      $display("FAIL t1_reset: got v=%b rdy=%b d=%h want 0 0 0", m_valid1, s_ready1, m_data1);
    end
    RST = 1'b0; #1;
    n_chk++;
    if (ram_we1 !== 4'hF || ram_a1 !== AW'(0) || s_ready1 !== 1'b0) begin
      n_err++;
      $display("FAIL t1_init: got we=%h a=%0d rdy=%b want F 0 0", ram_we1, ram_a1, s_ready1);
    end
    step();
    s_valid1 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      s_data1 = vals[n]; #1;
      n_chk++;
      if (s_ready1 !== 1'b1 || ram_we1 !== 4'hF || ram_a1 !== AW'(0) || ram_di1 !== vals[n]) begin
        n_err++;
        $display("FAIL t1_write%0d: got rdy=%b we=%h a=%0d di=%h want 1 F 0 %h",
                 n, s_ready1, ram_we1, ram_a1, ram_di1, vals[n]);
      end
      step(); #1;
      n_chk++;
      if (s_ready1 !== 1'b0 || ram_en1 !== 1'b1 || ram_we1 !== 4'h0 || m_valid1 !== 1'b0) begin
        n_err++;
        $display("FAIL t1_read%0d: got rdy=%b en=%b we=%h v=%b want 0 1 0 0",
                 n, s_ready1, ram_en1, ram_we1, m_valid1);
      end
      step(); #1;
      n_chk++;
      if (m_valid1 !== 1'b1 || m_first1 !== 1'b1 || m_last1 !== 1'b1 || m_tap1 !== 1'b0 ||
          m_data1 !== vals[n] || s_ready1 !== 1'b0) begin
        n_err++;
        $display("FAIL t1_beat%0d: got v=%b f=%b l=%b tap=%0d d=%h rdy=%b want 1 1 1 0 %h 0",
                 n, m_valid1, m_first1, m_last1, m_tap1, m_data1, s_ready1, vals[n]);
      end
      if (n == 2) s_valid1 = 1'b0;
      step();
    end
    #1;
    n_chk++;
    if (s_ready1 !== 1'b1 || m_valid1 !== 1'b0) begin
      n_err++;
      $display("FAIL t1_end: got rdy=%b v=%b want 1 0", s_ready1, m_valid1);
    end
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 32'h0;
    flush1 = 1'b0; s_valid1 = 1'b0; s_data1 = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_taps1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
